// File: rtl/puf_pkg.sv
// Shared definitions for the ring-oscillator PUF response generator.
// Holds the FSM state encoding and the default parameter values.
package puf_pkg;

    localparam int unsigned SEL_W_DEF         = 5;
    localparam int unsigned CNT_W_DEF         = 16;
    localparam int unsigned WIN_CYCLES_DEF    = 1024;
    localparam int unsigned SETTLE_CYCLES_DEF = 4;
    localparam int unsigned RESP_BITS_DEF     = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/puf_edge_cnt.sv
// Edge counter for one oscillator mux output.
// Ports:
//   clk, rst_n  clock and synchronous active-high reset
//   ro          raw asynchronous oscillator output
//   clr         holds the counter at zero
//   en          allows counting of synchronized rising edges
//   cnt         saturating edge count
module puf_edge_cnt
    import puf_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic s1;
    logic s2;
    logic s3;
    logic rise_c;

    // Two-flop synchronizer plus a delay flop; runs regardless of state
    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= ro;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_c = s2 & ~s3;

    // Saturating counter so a very fast oscillator cannot wrap and lose the comparison
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && rise_c && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/puf_resp_gen.sv
// Ring-oscillator PUF response generator.
// Selects an oscillator pair per challenge bit, counts edges of both over a
// fixed window, and builds one response bit per pair from the comparison.
// Ports:
//   clk, rst_n         clock and synchronous active-high reset
//   start, chal_seed   run request and base challenge
//   ro_a, ro_b         raw oscillator mux outputs
//   osc_en, sel_a/b    oscillator enable and bank selects
//   busy               high outside IDLE
//   resp, resp_valid, resp_ready   response word and handshake
module puf_resp_gen
    import puf_pkg::*;
#(
    parameter int unsigned SEL_W         = SEL_W_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned WIN_CYCLES    = WIN_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned RESP_BITS     = RESP_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SEL_W-1:0]     chal_seed,
    input  logic                 ro_a,
    input  logic                 ro_b,
    output logic                 osc_en,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    output logic                 busy,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    input  logic                 resp_ready
);

    localparam int unsigned TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned K_W     = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    state_t               state;
    state_t               state_d;
    logic [TMR_W-1:0]     tmr;
    logic [TMR_W-1:0]     tmr_d;
    logic [K_W-1:0]       k;
    logic [K_W-1:0]       k_d;
    logic [K_W-1:0]       k_nxt;
    logic [SEL_W-1:0]     seed;
    logic [SEL_W-1:0]     seed_d;
    logic [SEL_W-1:0]     sel_a_d;
    logic [SEL_W-1:0]     sel_b_d;
    logic [RESP_BITS-1:0] resp_d;
    logic                 clr_c;
    logic                 cnt_en_c;
    logic                 a_gt_b_c;
    logic [CNT_W-1:0]     cnt_a;
    logic [CNT_W-1:0]     cnt_b;

    puf_edge_cnt #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ro    (ro_a),
        .clr   (clr_c),
        .en    (cnt_en_c),
        .cnt   (cnt_a)
    );

    puf_edge_cnt #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ro    (ro_b),
        .clr   (clr_c),
        .en    (cnt_en_c),
        .cnt   (cnt_b)
    );

    assign a_gt_b_c = (cnt_a > cnt_b);

    // State and datapath registers; outputs are decoded from the next state
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            tmr        <= '0;
            k          <= '0;
            seed       <= '0;
            sel_a      <= '0;
            sel_b      <= '0;
            resp       <= '0;
            osc_en     <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_d;
            tmr        <= tmr_d;
            k          <= k_d;
            seed       <= seed_d;
            sel_a      <= sel_a_d;
            sel_b      <= sel_b_d;
            resp       <= resp_d;
            osc_en     <= (state_d == SETTLE) || (state_d == MEASURE);
            busy       <= (state_d != IDLE);
            resp_valid <= (state_d == DONE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state;
        tmr_d    = tmr;
        k_d      = k;
        seed_d   = seed;
        sel_a_d  = sel_a;
        sel_b_d  = sel_b;
        resp_d   = resp;
        cnt_en_c = 1'b0;
        k_nxt    = k + K_W'(1);

        case (state)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    seed_d  = chal_seed;
                    k_d     = '0;
                    resp_d  = '0;
                    tmr_d   = '0;
                    sel_a_d = chal_seed;
                    sel_b_d = chal_seed + SEL_W'(1);
                end
            end
            SETTLE: begin
                if (tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = MEASURE;
                end else begin
                    tmr_d = tmr + TMR_W'(1);
                end
            end
            MEASURE: begin
                cnt_en_c = 1'b1;
                if (tmr == TMR_W'(WIN_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = COMPARE;
                end else begin
                    tmr_d = tmr + TMR_W'(1);
                end
            end
            COMPARE: begin
                resp_d[k] = a_gt_b_c;
                if (k == K_W'(RESP_BITS - 1)) begin
                    state_d = DONE;
                end else begin
                    // Pair k+1 uses oscillators seed+2(k+1) and seed+2(k+1)+1, wrapping
                    k_d     = k_nxt;
                    sel_a_d = seed + SEL_W'({k_nxt, 1'b0});
                    sel_b_d = seed + SEL_W'({k_nxt, 1'b0}) + SEL_W'(1);
                    state_d = SETTLE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clearing on entry keeps both counters at zero for the whole settle period
        clr_c = (state_d == SETTLE);
    end

endmodule

// File: tb/tb_puf_resp_gen.sv
// Directed testbench for puf_resp_gen (SETTLE=4, WIN=16, RESP_BITS=4).
// A second instance with a 3-bit counter covers saturation.
module tb_puf_resp_gen;

    localparam int unsigned SEL_W = 5;
    localparam int unsigned RB    = 4;
    localparam int          BIT_CYC = 4 + 16 + 1;
    localparam int          VALID_CYC = 1 + RB * BIT_CYC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          start_s = 1'b0;
    logic [4:0]    chal_seed = '0;
    logic          ro_a = 1'b0;
    logic          ro_b = 1'b0;
    logic          resp_ready = 1'b1;

    logic          osc_en;
    logic [4:0]    sel_a;
    logic [4:0]    sel_b;
    logic          busy;
    logic [3:0]    resp;
    logic          resp_valid;

    logic          osc_en_s;
    logic [4:0]    sel_a_s;
    logic [4:0]    sel_b_s;
    logic          busy_s;
    logic [3:0]    resp_s;
    logic          resp_valid_s;

    int total = 0;
    int bad   = 0;

    // Oscillator model: half-period in clk cycles, 0 = static
    int ha = 0;
    int hb = 0;
    int pa = 0;
    int pb = 0;

    logic [4:0]  sa_log [4];
    logic [4:0]  sb_log [4];
    logic [15:0] ca21;
    logic [15:0] cb21;
    logic        osc21;
    int          cyc_got;

    puf_resp_gen #(
        .SEL_W(5), .CNT_W(16), .WIN_CYCLES(16), .SETTLE_CYCLES(4), .RESP_BITS(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .chal_seed  (chal_seed),
        .ro_a       (ro_a),
        .ro_b       (ro_b),
        .osc_en     (osc_en),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .busy       (busy),
        .resp       (resp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready)
    );

    puf_resp_gen #(
        .SEL_W(5), .CNT_W(3), .WIN_CYCLES(16), .SETTLE_CYCLES(4), .RESP_BITS(4)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_s),
        .chal_seed  (chal_seed),
        .ro_a       (ro_a),
        .ro_b       (ro_b),
        .osc_en     (osc_en_s),
        .sel_a      (sel_a_s),
        .sel_b      (sel_b_s),
        .busy       (busy_s),
        .resp       (resp_s),
        .resp_valid (resp_valid_s),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ha > 0) begin
            pa = pa + 1;
            if (pa >= ha) begin
                pa = 0;
                ro_a = ~ro_a;
            end
        end
        if (hb > 0) begin
            pb = pb + 1;
            if (pb >= hb) begin
                pb = 0;
                ro_b = ~ro_b;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a run and follow it until resp_valid; cyc_got is the cycle number
    // counted from the accepting edge (first SETTLE cycle is cycle 1)
    task automatic run_cap(input logic [4:0] seed, input bit poke);
        int cyc;
        chal_seed = seed;
        start = 1'b1;
        step();
        start = 1'b0;
        if (poke) chal_seed = 5'd9;
        cyc = 1;
        while (cyc < 300) begin
            if (((cyc - 1) % BIT_CYC == 0) && ((cyc - 1) / BIT_CYC < 4)) begin
                sa_log[(cyc - 1) / BIT_CYC] = sel_a;
                sb_log[(cyc - 1) / BIT_CYC] = sel_b;
            end
            if (cyc == 21) begin
                ca21  = dut.u_cnt_a.cnt;
                cb21  = dut.u_cnt_b.cnt;
                osc21 = osc_en;
            end
            if (resp_valid === 1'b1) break;
            if (poke) start = ((cyc % 7) == 3);
            step();
            cyc++;
        end
        start = 1'b0;
        cyc_got = cyc;
        total++;
        if (cyc >= 300) begin
            bad++;
            $display("FAIL run_timeout seed=%0d: resp_valid never rose", seed);
        end
    endtask

    task automatic check_sels(input string name, input logic [4:0] a0, input logic [4:0] b0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (sa_log[i] !== 5'(a0 + 5'(2 * i))) begin
                bad++;
                $display("FAIL %s sel_a[%0d]: got %0d want %0d", name, i, sa_log[i], 5'(a0 + 5'(2 * i)));
            end
            total++;
            if (sb_log[i] !== 5'(b0 + 5'(2 * i))) begin
                bad++;
                $display("FAIL %s sel_b[%0d]: got %0d want %0d", name, i, sb_log[i], 5'(b0 + 5'(2 * i)));
            end
        end
    endtask

    task automatic test_reset();
        ha = 1; hb = 3;
        rst_n = 1'b1;
        repeat (3) step();
        total++;
        if ({osc_en, sel_a, sel_b, busy, resp, resp_valid} !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs: got osc=%b a=%0d b=%0d busy=%b resp=%b v=%b want all 0",
                     osc_en, sel_a, sel_b, busy, resp, resp_valid);
        end
        rst_n = 1'b0;
        chal_seed = 5'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || osc_en !== 1'b1) begin
            bad++;
            $display("FAIL reset_start: got busy=%b osc_en=%b want 1 1", busy, osc_en);
        end
        total++;
        if (sel_a !== 5'd0 || sel_b !== 5'd1) begin
            bad++;
            $display("FAIL reset_start_sel: got %0d/%0d want 0/1", sel_a, sel_b);
        end
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        step();
    endtask

    task automatic test_rates();
        ha = 2; hb = 4;
        resp_ready = 1'b1;
        repeat (4) step();
        run_cap(5'd0, 1'b0);
        check_sels("rates_sel", 5'd0, 5'd1);
        total++;
        if (cyc_got != VALID_CYC) begin
            bad++;
            $display("FAIL rates_latency: got cycle %0d want %0d", cyc_got, VALID_CYC);
        end
        total++;
        if (resp !== 4'b1111) begin
            bad++;
            $display("FAIL rates_resp: got %b want 1111", resp);
        end
        total++;
        if (ca21 !== 16'd4 || cb21 !== 16'd2) begin
            bad++;
            $display("FAIL rates_counts: got %0d/%0d want 4/2", ca21, cb21);
        end
        total++;
        if (osc21 !== 1'b0) begin
            bad++;
            $display("FAIL compare_osc_en: got %b want 0", osc21);
        end
        step();
        total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL handshake_drop: got valid=%b busy=%b want 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_ties();
        int has [3] = '{4, 2, 0};
        int hbs [3] = '{2, 2, 0};
        for (int t = 0; t < 3; t++) begin
            ha = has[t]; hb = hbs[t];
            repeat (6) step();
            run_cap(5'd7, 1'b0);
            total++;
            if (resp !== 4'b0000) begin
                bad++;
                $display("FAIL tie_resp case%0d: got %b want 0000", t, resp);
            end
            step();
        end
    endtask

    task automatic test_wrap_ignore();
        ha = 2; hb = 4;
        repeat (4) step();
        run_cap(5'd31, 1'b1);
        check_sels("wrap_sel", 5'd31, 5'd0);
        total++;
        if (cyc_got != VALID_CYC) begin
            bad++;
            $display("FAIL wrap_latency: got cycle %0d want %0d", cyc_got, VALID_CYC);
        end
        total++;
        if (resp !== 4'b1111) begin
            bad++;
            $display("FAIL wrap_resp: got %b want 1111", resp);
        end
        step();
    endtask

    task automatic test_back_to_back();
        resp_ready = 1'b0;
        run_cap(5'd3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (resp_valid !== 1'b1 || resp !== 4'b1111) begin
                bad++;
                $display("FAIL backpressure cyc%0d: got valid=%b resp=%b want 1 1111", i, resp_valid, resp);
            end
        end
        resp_ready = 1'b1;
        step();
        total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: got valid=%b busy=%b want 0 0", resp_valid, busy);
        end
        chal_seed = 5'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL restart: got busy=%b want 1", busy);
        end
    endtask

    // Continues the run begun by test_back_to_back
    task automatic test_mid_reset();
        bit seen;
        repeat (49) step();
        total++;
        if (osc_en !== 1'b1 || sel_a !== 5'd4 || resp !== 4'b0011) begin
            bad++;
            $display("FAIL pre_reset: got osc=%b sel_a=%0d resp=%b want 1 4 0011", osc_en, sel_a, resp);
        end
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        total++;
        if (busy !== 1'b0 || osc_en !== 1'b0 || resp !== 4'b0000 || resp_valid !== 1'b0 || sel_a !== 5'd0) begin
            bad++;
            $display("FAIL mid_reset: got busy=%b osc=%b resp=%b v=%b sel_a=%0d want all 0",
                     busy, osc_en, resp, resp_valid, sel_a);
        end
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (resp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL no_partial: got activity after reset want idle");
        end
    endtask

    task automatic test_saturation();
        int cyc;
        logic [2:0] c21;
        ha = 1; hb = 2;
        repeat (4) step();
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        cyc = 1;
        c21 = '0;
        while (cyc < 300 && resp_valid_s !== 1'b1) begin
            if (cyc == 21) c21 = dut_s.u_cnt_a.cnt;
            step();
            cyc++;
        end
        total++;
        if (c21 !== 3'd7) begin
            bad++;
            $display("FAIL sat_count: got %0d want 7", c21);
        end
        total++;
        if (resp_valid_s !== 1'b1 || resp_s !== 4'b1111) begin
            bad++;
            $display("FAIL sat_resp: got valid=%b resp=%b want 1 1111", resp_valid_s, resp_s);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_rates();
        test_ties();
        test_wrap_ignore();
        ha = 2; hb = 4;
        test_back_to_back();
        test_mid_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/puf_resp_gen.md
# puf_resp_gen

Response generator for the ring-oscillator PUF. It drives the two oscillator-bank mux selects and the oscillator enable. It counts synchronized rising edges of the two selected oscillator outputs over a fixed clock window and compares the two counts. It assembles one response bit per challenge pair into a response word, which is handed downstream over a valid/ready handshake.

## Interface
Parameters:
- SEL_W, 5, width of each oscillator-bank select (32 oscillators per bank)
- CNT_W, 16, edge-counter width; counters saturate
- WIN_CYCLES, 1024, measurement window length in clk cycles
- SETTLE_CYCLES, 4, oscillator start-up / synchronizer flush cycles before each window (≥3)
- RESP_BITS, 8, response bits per run

Ports:
- clk  in  1  sole clock
- rst_n  in  1  reset; synchronous, active-high despite the name
- start  in  1  single-cycle request; honoured only in IDLE
- chal_seed  in  SEL_W  base challenge, sampled on accepted start
- ro_a  in  1  raw output of bank-A oscillator mux (asynchronous)
- ro_b  in  1  raw output of bank-B oscillator mux (asynchronous)
- osc_en  out  1  oscillator enable
- sel_a  out  SEL_W  bank-A select
- sel_b  out  SEL_W  bank-B select
- busy  out  1  high in every state except IDLE
- resp  out  RESP_BITS  response word
- resp_valid  out  1  response available
- resp_ready  in  1  downstream accepts response

## Operation
- States: IDLE, SETTLE, MEASURE, COMPARE, DONE.
- IDLE: start=1 latches chal_seed, clears bit index k, clears resp, and moves to SETTLE.
- Selects for bit k: sel_a = (seed + 2k) mod 2^SEL_W; sel_b = (seed + 2k + 1) mod 2^SEL_W. Selects are valid for the whole SETTLE and MEASURE period of bit k.
- SETTLE: osc_en=1. Both counters are held at 0 for SETTLE_CYCLES, then the block moves to MEASURE.
- MEASURE: osc_en=1. Each synchronized rising edge increments its counter. Counters saturate at 2^CNT_W−1. After WIN_CYCLES cycles, move to COMPARE.
- COMPARE (1 cycle): osc_en=0. resp[k] = (cnt_a > cnt_b); a tie gives 0. If k = RESP_BITS−1, go to DONE; otherwise increment k and go to SETTLE.
- DONE: resp_valid=1. resp is held stable until resp_valid & resp_ready, then the block goes to IDLE.
- Edge path per input: two-flop synchronizer, then a delay flop. edge = s2 & ~s3. Synchronizer flops run in every state.
- start while busy is ignored. start asserted in the same cycle as the DONE handshake is also ignored.
- Reset values: all outputs 0, state IDLE, counters, synchronizers, k and seed all 0.
- Reset asserted mid-run returns the block to IDLE on the next edge. No partial response is produced.

## Timing
- Start accepted at edge 0 → SETTLE from cycle 1; busy=1 and osc_en=1 from cycle 1.
- Per-bit cost: SETTLE_CYCLES + WIN_CYCLES + 1 cycles.
- resp_valid rises at cycle 1 + RESP_BITS·(SETTLE_CYCLES + WIN_CYCLES + 1) after the accepting edge.
- Handshake: if ready=1 in the first DONE cycle, valid lasts exactly 1 cycle. The next cycle is IDLE with busy=0, and a start in that cycle is accepted.
- Edges from ro_* reach the counter 3 cycles after the raw transition. SETTLE_CYCLES ≥ 3 discards edges from the previous selection.
- sel_a/sel_b change on the COMPARE→SETTLE edge only.

## Structure
- Package puf_pkg holds:
  - the state enum (IDLE, SETTLE, MEASURE, COMPARE, DONE);
  - the SEL_W default;
  - the default CNT_W, WIN_CYCLES, SETTLE_CYCLES and RESP_BITS values.
- Sub-module puf_edge_cnt is instantiated twice (A and B). It contains the synchronizer, the edge detector, and a saturating CNT_W counter with clear and count-enable inputs.
- The top level holds the FSM, window/settle timer, bit index, select arithmetic and response shift register.

## Test plan
Bench parameters: SETTLE_CYCLES=4, WIN_CYCLES=16, RESP_BITS=4, CNT_W=16.
- Reset: hold rst_n=1 for 3 cycles with ro_a/ro_b toggling → all outputs 0, busy=0. Then deassert and start=1 with seed 0 → busy=1 next cycle.
- ro_a toggles every 2 clk, ro_b every 4 clk, seed=0 → selects go (0,1),(2,3),(4,5),(6,7). resp_valid rises at cycle 85 with resp=4'b1111, and counts are 4 vs 2 per window.
- Swap rates → resp=4'b0000. Identical rates, including both static → resp=4'b0000 (tie rule).
- seed=31 → sel_a sequence 31,1,3,5 and sel_b sequence 0,2,4,6 (wrap). start pulses during the run are ignored, with no restart and the same cycle count.
- Backpressure: resp_ready=0 for 10 cycles in DONE → resp_valid and resp stay stable. ready=1 → valid drops next cycle; start in that cycle begins a new run.
- Reset mid-MEASURE of bit 2 → IDLE next cycle, osc_en=0, resp=0. Saturation: CNT_W=3 with ro_a toggling every clk → cnt_a holds at 7.
